// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Purpose:
//   Shares one single-port, fixed-latency memory between the instruction-fetch
//   port (I, read-only) and the load/store port (D, read/write) of the
//   multi-cycle CPU. One requester is granted per transaction. The arbiter
//   holds address, data and control steady on the memory for MEM_LAT cycles,
//   captures the read data and then returns a one-cycle ack to the winner.
//
// Configuration:
//   MEM_ARB_RR_EN  defined   -> round-robin between I and D when both request
//                  undefined -> fixed priority, D beats I
//
// Parameters:
//   ADDR_W   address width for both ports and the memory
//   DATA_W   data width
//   MEM_LAT  memory access cycles per transaction, 1..15
//
// Ports:
//   clk, Reset                 clock, asynchronous active-low reset
//   i_req/i_addr               fetch request (held until i_ack) and address
//   i_rdata/i_ack              registered fetch data, one-cycle completion
//   d_req/d_we/d_addr/d_wdata  load/store request (held until d_ack)
//   d_rdata/d_ack              registered load data, one-cycle completion
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata   memory macro interface
//   busy                       high while a transaction is in flight
//   grant                      0 = I, 1 = D; valid while busy
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int MEM_LAT = 2
) (
   input  logic              clk,
   input  logic              Reset,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic [DATA_W-1:0] i_rdata,
   output logic              i_ack,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_ack,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy,
   output logic              grant
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

`ifdef MEM_ARB_RR_EN
   localparam logic RR_EN = 1'b1;
`else
   localparam logic RR_EN = 1'b0;
`endif

   state_t              state, state_nxt;
   logic [3:0]          cnt;
   logic                grant_q;     // 0 = I, 1 = D for the transaction in flight
   logic                last_grant;  // winner of the most recently completed transaction
   logic                lat_we;
   logic [ADDR_W-1:0]   lat_addr;
   logic [DATA_W-1:0]   lat_wdata;
   logic                pick_d;
   logic                start;

   // D wins when it is the only requester, or under contention when fixed
   // priority is selected or the round-robin turn points away from D.
   assign pick_d = d_req & (~i_req | ~RR_EN | ~last_grant);
   assign start  = (state == IDLE) & (i_req | d_req);

   // State register
   always_ff @(posedge clk or negedge Reset) begin
      if (!Reset) begin
         state <= IDLE;
      end else begin
         // NOTE: every clocked assignment is non-blocking so all registers
         // update from pre-edge values regardless of statement order.
         state <= state_nxt;
      end
   end

   // Next state and all combinational outputs. Memory outputs decode from the
   // registered state, so an asynchronous reset drops mem_en immediately.
   always_comb begin
      // NOTE: every output of this block gets a default first so no path
      // through the case statement can infer a latch.
      state_nxt = state;
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      busy      = 1'b0;
      grant     = 1'b0;
      i_ack     = 1'b0;
      d_ack     = 1'b0;
      unique case (state)
         IDLE: begin
            if (i_req | d_req) state_nxt = ACCESS;
         end
         ACCESS: begin
            mem_en    = 1'b1;
            mem_we    = lat_we;
            mem_addr  = lat_addr;
            mem_wdata = lat_wdata;
            busy      = 1'b1;
            grant     = grant_q;
            if (cnt == 4'd0) state_nxt = RESP;
         end
         RESP: begin
            busy      = 1'b1;
            grant     = grant_q;
            i_ack     = ~grant_q;
            d_ack     = grant_q;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Transaction latches, counter and read-data capture
   always_ff @(posedge clk or negedge Reset) begin
      if (!Reset) begin
         // NOTE: the read-data registers are plain flops, not a memory array,
         // and must read zero out of reset, so they sit in the reset branch.
         cnt        <= '0;
         grant_q    <= 1'b0;
         last_grant <= 1'b0;
         lat_we     <= 1'b0;
         lat_addr   <= '0;
         lat_wdata  <= '0;
         i_rdata    <= '0;
         d_rdata    <= '0;
      end else begin
         if (start) begin
            grant_q   <= pick_d;
            lat_we    <= pick_d & d_we;
            lat_addr  <= pick_d ? d_addr  : i_addr;
            lat_wdata <= pick_d ? d_wdata : '0;
            cnt       <= CNT_INIT;
         end

         if (state == ACCESS) begin
            if (cnt == 4'd0) begin
               // Stores complete without touching d_rdata.
               if (!lat_we) begin
                  if (grant_q) d_rdata <= mem_rdata;
                  else         i_rdata <= mem_rdata;
               end
            end else begin
               cnt <= cnt - 4'd1;
            end
         end

         if (state == RESP) last_grant <= grant_q;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Table-driven cycle-by-cycle vectors against a MEM_LAT=2 instance, plus
// hand-written sequences for arbitration policy and reset during a MEM_LAT=4
// transaction (second instance sharing the same inputs).
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

   localparam logic N = 1'b0;
   localparam logic Y = 1'b1;

   typedef struct packed {
      logic        en;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        iack;
      logic        dack;
      logic        busy;
      logic        grant;
      logic [31:0] ird;
      logic [31:0] drd;
   } out_t;

   typedef struct {
      logic        ir;
      logic [31:0] ia;
      logic        dr;
      logic        dw;
      logic [31:0] da;
      logic [31:0] dwd;
      logic [31:0] rd;
      out_t        exp;
   } vec_t;

   logic        clk = 1'b0;
   logic        Reset;
   logic        i_req, d_req, d_we;
   logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;

   // MEM_LAT=2 instance
   logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
   logic        i_ack, d_ack, mem_en, mem_we, busy, grant;
   // MEM_LAT=4 instance
   logic [31:0] i_rdata_4, d_rdata_4, mem_addr_4, mem_wdata_4;
   logic        i_ack_4, d_ack_4, mem_en_4, mem_we_4, busy_4, grant_4;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) dut (
      .clk(clk), .Reset(Reset),
      .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_ack(d_ack),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .busy(busy), .grant(grant)
   );

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(4)) dut4 (
      .clk(clk), .Reset(Reset),
      .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata_4), .i_ack(i_ack_4),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata_4), .d_ack(d_ack_4),
      .mem_en(mem_en_4), .mem_we(mem_we_4), .mem_addr(mem_addr_4),
      .mem_wdata(mem_wdata_4), .mem_rdata(mem_rdata),
      .busy(busy_4), .grant(grant_4)
   );

   function automatic out_t get_out();
      return '{en: mem_en, we: mem_we, addr: mem_addr, wdata: mem_wdata,
               iack: i_ack, dack: d_ack, busy: busy, grant: grant,
               ird: i_rdata, drd: d_rdata};
   endfunction

   function automatic out_t get_out4();
      return '{en: mem_en_4, we: mem_we_4, addr: mem_addr_4, wdata: mem_wdata_4,
               iack: i_ack_4, dack: d_ack_4, busy: busy_4, grant: grant_4,
               ird: i_rdata_4, drd: d_rdata_4};
   endfunction

   function automatic vec_t row(
      input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
      input logic [31:0] da, input logic [31:0] dwd, input logic [31:0] rd,
      input logic en, input logic we, input logic [31:0] ma, input logic [31:0] mwd,
      input logic iack, input logic dack, input logic bsy, input logic gr,
      input logic [31:0] ird, input logic [31:0] drd);
      vec_t v;
      v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da; v.dwd = dwd; v.rd = rd;
      v.exp = '{en: en, we: we, addr: ma, wdata: mwd, iack: iack, dack: dack,
                busy: bsy, grant: gr, ird: ird, drd: drd};
      return v;
   endfunction

   task automatic check_out(input string name, input out_t act, input out_t exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got en=%b we=%b addr=%h wdata=%h iack=%b dack=%b busy=%b grant=%b ird=%h drd=%h, want en=%b we=%b addr=%h wdata=%h iack=%b dack=%b busy=%b grant=%b ird=%h drd=%h",
                  name, act.en, act.we, act.addr, act.wdata, act.iack, act.dack,
                  act.busy, act.grant, act.ird, act.drd,
                  exp.en, exp.we, exp.addr, exp.wdata, exp.iack, exp.dack,
                  exp.busy, exp.grant, exp.ird, exp.drd);
      end
   endtask

   task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic ir, input logic [31:0] ia, input logic dr,
                        input logic dw, input logic [31:0] da,
                        input logic [31:0] dwd, input logic [31:0] rd);
      i_req = ir; i_addr = ia; d_req = dr; d_we = dw;
      d_addr = da; d_wdata = dwd; mem_rdata = rd;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, want $finish before 100000");
      $fatal(1);
   end

   initial begin
      vec_t        vecs[19];
      logic [3:0]  exp_seq;
      logic [3:0]  got;
      logic        both_ack;
      logic        saw_ack;
      int          n_ack;
      int          ack_at;

      // Store, then fetch, then contention (D first, then I).
      vecs[0]  = row(N, 0, Y, Y, 32'h20, 32'h1234, 0,            N, N, 0, 0,            N, N, N, N, 0, 0);
      vecs[1]  = row(N, 0, Y, Y, 32'h20, 32'h1234, 0,            Y, Y, 32'h20, 32'h1234, N, N, Y, Y, 0, 0);
      vecs[2]  = row(N, 0, Y, Y, 32'h20, 32'h5555, 32'hFFFFFFFF, Y, Y, 32'h20, 32'h1234, N, N, Y, Y, 0, 0);
      vecs[3]  = row(N, 0, Y, Y, 32'h20, 32'h5555, 0,            N, N, 0, 0,            N, Y, Y, Y, 0, 0);
      vecs[4]  = row(N, 0, N, N, 0, 0, 0,                        N, N, 0, 0,            N, N, N, N, 0, 0);
      vecs[5]  = row(Y, 32'h10, N, N, 0, 0, 0,                   N, N, 0, 0,            N, N, N, N, 0, 0);
      vecs[6]  = row(Y, 32'h10, N, N, 0, 0, 0,                   Y, N, 32'h10, 0,       N, N, Y, N, 0, 0);
      vecs[7]  = row(Y, 32'h99, N, N, 0, 0, 32'hDEADBEEF,        Y, N, 32'h10, 0,       N, N, Y, N, 0, 0);
      vecs[8]  = row(Y, 32'h99, N, N, 0, 0, 0,                   N, N, 0, 0,            Y, N, Y, N, 32'hDEADBEEF, 0);
      vecs[9]  = row(N, 0, N, N, 0, 0, 0,                        N, N, 0, 0,            N, N, N, N, 32'hDEADBEEF, 0);
      vecs[10] = row(Y, 32'h50, Y, N, 32'h40, 0, 0,              N, N, 0, 0,            N, N, N, N, 32'hDEADBEEF, 0);
      vecs[11] = row(Y, 32'h50, Y, N, 32'h40, 0, 0,              Y, N, 32'h40, 0,       N, N, Y, Y, 32'hDEADBEEF, 0);
      vecs[12] = row(Y, 32'h50, Y, N, 32'h40, 0, 32'hA5A5,       Y, N, 32'h40, 0,       N, N, Y, Y, 32'hDEADBEEF, 0);
      vecs[13] = row(Y, 32'h50, Y, N, 32'h40, 0, 0,              N, N, 0, 0,            N, Y, Y, Y, 32'hDEADBEEF, 32'hA5A5);
      vecs[14] = row(Y, 32'h50, N, N, 0, 0, 0,                   N, N, 0, 0,            N, N, N, N, 32'hDEADBEEF, 32'hA5A5);
      vecs[15] = row(Y, 32'h50, N, N, 0, 0, 0,                   Y, N, 32'h50, 0,       N, N, Y, N, 32'hDEADBEEF, 32'hA5A5);
      vecs[16] = row(Y, 32'h50, N, N, 0, 0, 32'hCAFE0001,        Y, N, 32'h50, 0,       N, N, Y, N, 32'hDEADBEEF, 32'hA5A5);
      vecs[17] = row(Y, 32'h50, N, N, 0, 0, 0,                   N, N, 0, 0,            Y, N, Y, N, 32'hCAFE0001, 32'hA5A5);
      vecs[18] = row(N, 0, N, N, 0, 0, 0,                        N, N, 0, 0,            N, N, N, N, 32'hCAFE0001, 32'hA5A5);

`ifdef MEM_ARB_RR_EN
      exp_seq = 4'b0101;  // bit k = grant of k-th transaction: D,I,D,I
`else
      exp_seq = 4'b1111;  // D,D,D,D
`endif

      // Reset held with random inputs
      Reset = 1'b0;
      drive(N, 0, N, N, 0, 0, 0);
      for (int c = 0; c < 4; c++) begin
         @(posedge clk); #1;
         drive(1'($urandom), $urandom, 1'($urandom), 1'($urandom), $urandom, $urandom, $urandom);
         @(negedge clk);
         check_out($sformatf("reset_hold%0d", c), get_out(), '0);
         check_out($sformatf("reset_hold4_%0d", c), get_out4(), '0);
      end

      // Release with no requests: stays idle
      @(posedge clk); #1;
      drive(N, 0, N, N, 0, 0, 0);
      Reset = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check_out($sformatf("idle_after_reset%0d", c), get_out(), '0);
         @(posedge clk); #1;
      end

      // Table vectors
      for (int i = 0; i < 19; i++) begin
         if (i > 0) begin
            @(posedge clk); #1;
         end
         drive(vecs[i].ir, vecs[i].ia, vecs[i].dr, vecs[i].dw,
               vecs[i].da, vecs[i].dwd, vecs[i].rd);
         @(negedge clk);
         check_out($sformatf("vec%0d", i), get_out(), vecs[i].exp);
      end

      // Arbitration policy: both requests held for four transactions
      @(posedge clk); #1;
      drive(Y, 32'h60, Y, N, 32'h70, 0, 32'h1111);
      n_ack = 0;
      got = '0;
      both_ack = 1'b0;
      for (int c = 0; c < 40 && n_ack < 4; c++) begin
         @(negedge clk);
         if (i_ack && d_ack) both_ack = 1'b1;
         if (i_ack || d_ack) begin
            got[n_ack] = d_ack;
            n_ack++;
         end
      end
      check_val("policy_ack_count", n_ack, 4);
      check_val("policy_single_ack", {31'd0, both_ack}, 0);
      for (int k = 0; k < 4; k++)
         check_val($sformatf("policy_grant%0d", k), {31'd0, got[k]}, {31'd0, exp_seq[k]});

      @(posedge clk); #1;
      drive(N, 0, N, N, 0, 0, 0);
      for (int c = 0; c < 8; c++) @(posedge clk);
      #1;
      check_val("idle_before_reset_test", {30'd0, busy, busy_4}, 0);

      // Reset during a MEM_LAT=4 load
      drive(N, 0, Y, N, 32'h80, 0, 32'h77);   // cycle 0: IDLE samples request
      @(posedge clk); #1;                      // cycle 1: ACCESS
      check_val("rst_pre_mem_en", {31'd0, mem_en_4}, 1);
      check_val("rst_pre_mem_addr", mem_addr_4, 32'h80);
      #2;
      Reset = 1'b0;
      #1;                                      // no clock edge since Reset fell
      check_val("rst_async_drop", {28'd0, mem_en_4, mem_we_4, busy_4, d_ack_4}, 0);
      @(posedge clk); #1;
      drive(N, 0, N, N, 0, 0, 32'h77);
      Reset = 1'b1;
      saw_ack = 1'b0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (d_ack_4 || i_ack_4) saw_ack = 1'b1;
      end
      check_val("rst_no_ack", {31'd0, saw_ack}, 0);
      check_val("rst_idle", {31'd0, busy_4}, 0);

      // Fresh load after reset completes normally: ack in cycle MEM_LAT+1
      @(posedge clk); #1;
      drive(N, 0, Y, N, 32'h84, 0, 32'h77);
      ack_at = -1;
      for (int c = 0; c < 12 && ack_at < 0; c++) begin
         @(negedge clk);
         if (d_ack_4) ack_at = c;
      end
      check_val("fresh_ack_cycle", ack_at, 5);
      check_val("fresh_rdata", d_rdata_4, 32'h77);
      @(posedge clk); #1;
      drive(N, 0, N, N, 0, 0, 0);
      @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-port, fixed-latency unified memory between two requesters of the multi-cycle CPU:
- the instruction-fetch side (I-port, read-only);
- the load/store side (D-port, read/write).

Operation:
- Grants one requester per transaction.
- Holds address, data and control steady on the memory for MEM_LAT cycles.
- Captures read data and returns a one-cycle ack to the winner.
- Sits between the control unit's IF/MEM phases and the memory macro.

Parameters:
- ADDR_W, 32, address width for both ports and memory.
- DATA_W, 32, data width.
- MEM_LAT, 2, memory access cycles per transaction; legal range 1..15.

Ports:
- CLK  in  1  system clock; all state updates on posedge.
- Reset  in  1  asynchronous, active-low reset.
- i_req  in  1  fetch request; held until i_ack.
- i_addr  in  ADDR_W  fetch address.
- i_rdata  out  DATA_W  fetched word, registered.
- i_ack  out  1  one-cycle fetch completion.
- d_req  in  1  load/store request; held until d_ack.
- d_we  in  1  1=store, 0=load.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_rdata  out  DATA_W  load result, registered.
- d_ack  out  1  one-cycle load/store completion.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; valid in the last ACCESS cycle.
- busy  out  1  high in ACCESS and RESP.
- grant  out  1  0=I, 1=D; valid while busy.

Behaviour:
- Reset (Reset=0, asynchronous):
  - state=IDLE, counter=0, last_grant=I.
  - All outputs 0, including i_rdata, d_rdata, mem_addr and mem_wdata.
- FSM has three states: IDLE, ACCESS, RESP.
- IDLE:
  - Samples i_req and d_req.
  - If either is high: pick a winner, latch its addr/we/wdata into internal registers, set grant, counter=MEM_LAT-1, go to ACCESS.
  - Otherwise stay in IDLE.
  - Memory outputs are 0 in IDLE.
- ACCESS:
  - mem_en=1, mem_we=latched we (always 0 for I), mem_addr/mem_wdata from latched registers.
  - All memory outputs are steady for exactly MEM_LAT cycles.
  - Counter decrements each cycle.
  - When counter==0: capture mem_rdata into i_rdata or d_rdata (loads/fetches only), go to RESP.
- RESP:
  - Asserts i_ack or d_ack (matching grant) for exactly one cycle, then returns to IDLE.
  - last_grant is updated to grant.
- Latency: request seen in IDLE at cycle 0 → mem_en in cycles 1..MEM_LAT → ack in cycle MEM_LAT+1. Throughput is one transaction per MEM_LAT+2 cycles.
- Default arbitration is fixed priority: D beats I when both requests are high in IDLE.
- Request timing:
  - Requests are sampled only in IDLE; changes to req/addr/wdata during ACCESS/RESP are ignored.
  - A requester keeping req high after its ack cycle is treated as a new request.
- Read-data registers:
  - Stores leave d_rdata unchanged.
  - i_rdata and d_rdata change only on their own read completion.
  - Each holds its value indefinitely otherwise.
- Never more than one ack per cycle; i_ack and d_ack are mutually exclusive.
- Reset asserted mid-ACCESS or mid-RESP:
  - Immediate return to IDLE with mem_en/mem_we=0.
  - No ack is issued; the pending transaction is dropped.
- MEM_LAT=1: ACCESS lasts one cycle and the counter starts at 0.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: round-robin arbitration. When both requests are high in IDLE, the port not equal to last_grant wins. With last_grant=I after reset, the first contested grant goes to D. A single request always wins.
- Undefined: fixed D-over-I priority. last_grant is still maintained but does not affect the choice.

Test Plan:
- Reset: hold Reset=0 with random inputs → all outputs 0, busy=0; release, no req → stays IDLE, mem_en=0.
- Fetch, MEM_LAT=2: i_req=1, i_addr=0x10 at cycle 0, memory returns 0xDEADBEEF → mem_en=1, mem_addr=0x10 in cycles 1–2; i_ack=1 in cycle 3 only; i_rdata=0xDEADBEEF; d_ack stays 0.
- Store: d_req=1, d_we=1, d_addr=0x20, d_wdata=0x1234 → mem_we=1, mem_wdata=0x1234 in cycles 1–2; d_ack in cycle 3; d_rdata keeps its prior value.
- Contention: i_req and d_req (load 0x40→0xA5A5) both rise at cycle 0, each dropped after its ack → d_ack in cycle 3 with d_rdata=0xA5A5, then I is served with i_ack in cycle 7.
- Arbitration policy: both requests held high continuously for 4 transactions → with MEM_ARB_RR_EN grant sequence is D,I,D,I; without it, D,D,D,D and i_ack never fires.
- Reset mid-operation: Reset=0 in cycle 1 of a MEM_LAT=4 load → mem_en falls without a clock edge; no d_ack; after release the arbiter is in IDLE and a fresh request completes normally.
